// File: rtl/icache_nway.sv
// N-way set-associative blocking instruction cache with whole-line refill,
// uncached fetch bypass and CACOP index/hit invalidate.
module icache_nway #(
  parameter int NSET       = 256,
  parameter int NWAY       = 4,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_uncached_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [LINE_WIDTH-1:0] resp_data_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_uncached_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [LINE_WIDTH-1:0] mem_rdata_i,
  input  logic                  cacop_valid_i,
  output logic                  cacop_ready_o,
  input  logic [1:0]            cacop_mode_i,
  input  logic [ADDR_WIDTH-1:0] cacop_addr_i,
  output logic                  cacop_done_o
);

  localparam int INDEX_W = $clog2(NSET);
  localparam int WAY_W   = $clog2(NWAY);
  localparam int OFF_W   = $clog2(LINE_WIDTH / 8);
  localparam int TAG_W   = ADDR_WIDTH - INDEX_W - OFF_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP, CLOOKUP, CDONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    uncached_q, uncached_d;
  logic [1:0]              mode_q, mode_d;
  logic [LINE_WIDTH-1:0]   respData_q, respData_d;

  logic [NWAY-1:0]         validBits_q [NSET];
  logic [WAY_W-1:0]        rrPtr_q [NSET];
  logic [TAG_W-1:0]        tagMem [NSET][NWAY];
  logic [LINE_WIDTH-1:0]   dataMem [NSET][NWAY];
  logic [TAG_W-1:0]        tagRd_q [NWAY];
  logic [LINE_WIDTH-1:0]   dataRd_q [NWAY];

  logic [INDEX_W-1:0]      setIdx, rdIdx;
  logic [TAG_W-1:0]        addrTag;
  logic [NWAY-1:0]         hitVec;
  logic                    hit, anyInvalid, rdEn, fillEn, clrEn;
  logic [WAY_W-1:0]        hitWay, victimWay, clrWay;
  logic [LINE_WIDTH-1:0]   hitData;

  assign setIdx  = addr_q[OFF_W+INDEX_W-1:OFF_W];
  assign addrTag = addr_q[ADDR_WIDTH-1:OFF_W+INDEX_W];
  assign hit     = |hitVec;

  // Tag compare against the registered read of the set latched at accept.
  always_comb begin
    hitVec  = '0;
    hitWay  = '0;
    hitData = '0;
    for (int w = 0; w < NWAY; w++) begin
      hitVec[w] = validBits_q[setIdx][w] && (tagRd_q[w] == addrTag);
      if (hitVec[w]) begin
        hitWay  = WAY_W'(w);
        hitData = dataRd_q[w];
      end
    end
  end

  // Lowest-index invalid way wins; round-robin only when the set is full.
  always_comb begin
    victimWay  = rrPtr_q[setIdx];
    anyInvalid = 1'b0;
    for (int w = NWAY - 1; w >= 0; w--) begin
      if (!validBits_q[setIdx][w]) begin
        victimWay  = WAY_W'(w);
        anyInvalid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    uncached_d = uncached_q;
    mode_d     = mode_q;
    respData_d = respData_q;
    rdEn       = 1'b0;
    rdIdx      = req_addr_i[OFF_W+INDEX_W-1:OFF_W];
    fillEn     = 1'b0;
    clrEn      = 1'b0;
    clrWay     = hitWay;
    case (state_q)
      IDLE: begin
        if (cacop_valid_i) begin
          mode_d  = cacop_mode_i;
          addr_d  = cacop_addr_i;
          rdEn    = 1'b1;
          rdIdx   = cacop_addr_i[OFF_W+INDEX_W-1:OFF_W];
          state_d = CLOOKUP;
        end else if (req_valid_i) begin
          addr_d     = req_addr_i;
          uncached_d = req_uncached_i;
          rdEn       = 1'b1;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit && !uncached_q) begin
          respData_d = hitData;
          state_d    = RESP;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ:  if (mem_ready_i) state_d = MISS_WAIT;
      MISS_WAIT: begin
        if (mem_rvalid_i) begin
          respData_d = mem_rdata_i;
          fillEn     = !uncached_q;
          state_d    = RESP;
        end
      end
      RESP:    if (resp_ready_i) state_d = IDLE;
      CLOOKUP: state_d = CDONE;
      CDONE: begin
        state_d = IDLE;
        if (mode_q == 2'd0 || mode_q == 2'd1) begin
          clrEn  = 1'b1;
          clrWay = addr_q[WAY_W-1:0];
        end else if (mode_q == 2'd2) begin
          clrEn = hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      uncached_q <= 1'b0;
      mode_q     <= 2'd0;
      respData_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      uncached_q <= uncached_d;
      mode_q     <= mode_d;
      respData_q <= respData_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSET; s++) begin
        validBits_q[s] <= '0;
        rrPtr_q[s]     <= '0;
      end
    end else begin
      if (fillEn) begin
        validBits_q[setIdx][victimWay] <= 1'b1;
        if (!anyInvalid) rrPtr_q[setIdx] <= rrPtr_q[setIdx] + 1'b1;
      end
      if (clrEn) validBits_q[setIdx][clrWay] <= 1'b0;
    end
  end

  // Tag/data arrays behave as RAMs: no reset, one-cycle registered read.
  always_ff @(posedge clk) begin
    if (rdEn) begin
      for (int w = 0; w < NWAY; w++) begin
        tagRd_q[w]  <= tagMem[rdIdx][w];
        dataRd_q[w] <= dataMem[rdIdx][w];
      end
    end
    if (fillEn) begin
      tagMem[setIdx][victimWay]  <= addrTag;
      dataMem[setIdx][victimWay] <= mem_rdata_i;
    end
  end

  assign req_ready_o    = (state_q == IDLE) && !cacop_valid_i;
  assign cacop_ready_o  = (state_q == IDLE);
  assign mem_req_o      = (state_q == MISS_REQ);
  assign mem_uncached_o = mem_req_o && uncached_q;
  assign mem_addr_o     = !mem_req_o ? '0 :
                          uncached_q ? addr_q : {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign resp_valid_o   = (state_q == RESP);
  assign resp_data_o    = respData_q;
  assign cacop_done_o   = (state_q == CDONE);

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (NSET=256, NWAY=4, 128-bit lines): set 5 is
// addressed as {tag[19:0], 12'h050}, so tag t lives at t*0x1000 + 0x50.
module tb_icache_nway;

  localparam int MEMDLY = 3;

  logic         clk, rst_n;
  logic         req_valid_i, req_ready_o, req_uncached_i;
  logic [31:0]  req_addr_i;
  logic         resp_valid_o, resp_ready_i;
  logic [127:0] resp_data_o;
  logic         mem_req_o, mem_uncached_o, mem_ready_i, mem_rvalid_i;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_rdata_i;
  logic         cacop_valid_i, cacop_ready_o, cacop_done_o;
  logic [1:0]   cacop_mode_i;
  logic [31:0]  cacop_addr_i;

  int vectors = 0;
  int miscompares = 0;

  icache_nway #(.NSET(256), .NWAY(4), .LINE_WIDTH(128), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_uncached_i(req_uncached_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_uncached_o(mem_uncached_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .cacop_valid_i(cacop_valid_i), .cacop_ready_o(cacop_ready_o), .cacop_mode_i(cacop_mode_i),
    .cacop_addr_i(cacop_addr_i), .cacop_done_o(cacop_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] lineData(input logic [31:0] t);
    return {32'hCAFE_0000 + t, 32'h1234_5678, 32'hA5A5_0000 + t, t};
  endfunction

  function automatic logic [31:0] set5Addr(input logic [19:0] t);
    return {t, 12'h050};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One fetch; acts as the AXI controller (ready after MEMDLY request cycles,
  // single-beat rdata next cycle) and optionally stalls the response.
  task automatic applyStimulus(input logic [31:0] addr, input logic unc, input logic [127:0] rdata,
                               input int respHold, output logic missed, output logic [127:0] data,
                               output logic [31:0] maddr, output logic munc, output int lat);
    int reqCyc, phase, guard;
    missed = 1'b0; data = '0; maddr = '0; munc = 1'b0; lat = -1; reqCyc = 0; phase = 0;
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = addr; req_uncached_i = unc;
    guard = 0;
    while (!req_ready_o && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 req_valid_i = 1'b0; req_uncached_i = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (phase == 1) begin
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = rdata; phase = 2;
      end else if (phase == 2) begin
        mem_rvalid_i = 1'b0; phase = 3;
      end
      if (mem_req_o) begin
        if (!missed) begin
          maddr = mem_addr_o; munc = mem_uncached_o;
        end else if (mem_addr_o !== maddr || mem_uncached_o !== munc) begin
          maddr = 'x;
        end
        missed = 1'b1;
        reqCyc++;
        if (reqCyc > MEMDLY && phase == 0) begin mem_ready_i = 1'b1; phase = 1; end
      end
      if (resp_valid_o) begin
        lat = cyc; data = resp_data_o;
        for (int h = 0; h < respHold; h++) begin
          checkOutput("hold_data", resp_data_o, data);
          checkOutput("hold_req_ready", 128'(req_ready_o), 128'd0);
          @(negedge clk);
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1 resp_ready_i = 1'b0;
        break;
      end
    end
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic fetchCheck(input string tag, input logic [31:0] addr, input logic expMiss,
                            input logic [127:0] expData);
    logic m, u; logic [127:0] d; logic [31:0] a; int l;
    applyStimulus(addr, 1'b0, expData, 0, m, d, a, u, l);
    checkOutput({tag, "_miss"}, 128'(m), 128'(expMiss));
    checkOutput({tag, "_data"}, d, expData);
  endtask

  task automatic applyCacop(input string tag, input logic [1:0] mode, input logic [31:0] addr);
    int guard, lat; logic pulseOk;
    lat = -1; pulseOk = 1'b0;
    @(negedge clk);
    cacop_valid_i = 1'b1; cacop_mode_i = mode; cacop_addr_i = addr;
    guard = 0;
    while (!cacop_ready_o && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 cacop_valid_i = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cacop_done_o) begin
        lat = cyc;
        @(negedge clk);
        pulseOk = !cacop_done_o;
        break;
      end
    end
    checkOutput({tag, "_done_lat"}, 128'(lat), 128'd2);
    checkOutput({tag, "_one_pulse"}, 128'(pulseOk), 128'd1);
  endtask

  initial begin
    logic m, u; logic [127:0] d; logic [31:0] a; int l;
    rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_uncached_i = 1'b0;
    resp_ready_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    cacop_valid_i = 1'b0; cacop_mode_i = 2'd0; cacop_addr_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", 128'(req_ready_o), 128'd1);
    checkOutput("rst_cacop_ready", 128'(cacop_ready_o), 128'd1);
    checkOutput("rst_resp_valid", 128'(resp_valid_o), 128'd0);
    checkOutput("rst_resp_data", resp_data_o, 128'd0);
    checkOutput("rst_mem_req", 128'(mem_req_o), 128'd0);
    checkOutput("rst_mem_addr", 128'(mem_addr_o), 128'd0);
    checkOutput("rst_cacop_done", 128'(cacop_done_o), 128'd0);

    // Cold miss then hit in the same line.
    applyStimulus(32'h0000_1050, 1'b0, lineData(1), 0, m, d, a, u, l);
    checkOutput("cold_miss", 128'(m), 128'd1);
    checkOutput("cold_mem_addr", 128'(a), 128'h1050);
    checkOutput("cold_mem_unc", 128'(u), 128'd0);
    checkOutput("cold_data", d, lineData(1));
    applyStimulus(32'h0000_105C, 1'b0, 128'hDEAD, 0, m, d, a, u, l);
    checkOutput("rehit_miss", 128'(m), 128'd0);
    checkOutput("rehit_lat", 128'(l), 128'd2);
    checkOutput("rehit_data", d, lineData(1));

    // Fill set 5 (tag 1 is already way 0), then tag 5 evicts way 0.
    fetchCheck("fill_t2", set5Addr(2), 1'b1, lineData(2));
    fetchCheck("fill_t3", set5Addr(3), 1'b1, lineData(3));
    fetchCheck("fill_t4", set5Addr(4), 1'b1, lineData(4));
    fetchCheck("fill_t5", set5Addr(5), 1'b1, lineData(5));
    fetchCheck("hit_t2", set5Addr(2), 1'b0, lineData(2));
    fetchCheck("hit_t3", set5Addr(3), 1'b0, lineData(3));
    fetchCheck("hit_t4", set5Addr(4), 1'b0, lineData(4));
    fetchCheck("hit_t5", set5Addr(5), 1'b0, lineData(5));
    fetchCheck("evicted_t1", set5Addr(1), 1'b1, lineData(1));
    // Now ways: 0=t5 1=t1 2=t3 3=t4, pointer 2.

    applyCacop("idxinv_w2", 2'd0, 32'h0000_0052);
    fetchCheck("after_idx_t4", set5Addr(4), 1'b0, lineData(4));
    fetchCheck("after_idx_t1", set5Addr(1), 1'b0, lineData(1));
    fetchCheck("after_idx_t5", set5Addr(5), 1'b0, lineData(5));
    fetchCheck("after_idx_t3", set5Addr(3), 1'b1, lineData(3));
    applyCacop("idxinv_w0", 2'd1, 32'h0000_0050);
    fetchCheck("freed_t7", set5Addr(7), 1'b1, lineData(7));
    fetchCheck("freed_t3", set5Addr(3), 1'b0, lineData(3));
    fetchCheck("freed_t4", set5Addr(4), 1'b0, lineData(4));
    fetchCheck("freed_t1", set5Addr(1), 1'b0, lineData(1));

    applyCacop("hitinv_t4", 2'd2, 32'h0000_4058);
    fetchCheck("hitinv_t4_refetch", set5Addr(4), 1'b1, lineData(4));
    applyCacop("hitinv_absent", 2'd2, 32'hABCD_E050);
    fetchCheck("absent_t1", set5Addr(1), 1'b0, lineData(1));
    fetchCheck("absent_t7", set5Addr(7), 1'b0, lineData(7));
    applyCacop("noop", 2'd3, set5Addr(3));
    fetchCheck("noop_t3", set5Addr(3), 1'b0, lineData(3));

    // Uncached fetch of a resident line bypasses and leaves it intact.
    fetchCheck("uc_fill", 32'h1C00_0004, 1'b1, lineData(32'h1C));
    applyStimulus(32'h1C00_0004, 1'b1, lineData(32'h99), 0, m, d, a, u, l);
    checkOutput("uc_miss", 128'(m), 128'd1);
    checkOutput("uc_mem_addr", 128'(a), 128'h1C00_0004);
    checkOutput("uc_mem_unc", 128'(u), 128'd1);
    checkOutput("uc_data", d, lineData(32'h99));
    fetchCheck("uc_after", 32'h1C00_0008, 1'b0, lineData(32'h1C));

    // Response backpressure on a hit.
    applyStimulus(32'h0000_1058, 1'b0, 128'hBAD, 5, m, d, a, u, l);
    checkOutput("bp_miss", 128'(m), 128'd0);
    checkOutput("bp_data", d, lineData(1));

    // Simultaneous cacop and fetch: cacop wins.
    @(negedge clk);
    cacop_valid_i = 1'b1; cacop_mode_i = 2'd3; cacop_addr_i = '0;
    req_valid_i = 1'b1; req_addr_i = 32'h0000_1050;
    #1;
    checkOutput("prio_req_ready", 128'(req_ready_o), 128'd0);
    checkOutput("prio_cacop_ready", 128'(cacop_ready_o), 128'd1);
    @(posedge clk);
    #1 cacop_valid_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("prio_busy_req_ready", 128'(req_ready_o), 128'd0);
    @(negedge clk);
    checkOutput("prio_done", 128'(cacop_done_o), 128'd1);
    checkOutput("prio_no_resp", 128'(resp_valid_o), 128'd0);

    // Reset during MISS_WAIT.
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = set5Addr(9);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("rstmid_in_miss_req", 128'(mem_req_o), 128'd1);
    mem_ready_i = 1'b1;
    @(posedge clk);
    #1 mem_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_mem_req", 128'(mem_req_o), 128'd0);
    checkOutput("rstmid_resp_valid", 128'(resp_valid_o), 128'd0);
    checkOutput("rstmid_req_ready", 128'(req_ready_o), 128'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fetchCheck("post_rst_t1", set5Addr(1), 1'b1, lineData(1));
    fetchCheck("post_rst_uc", 32'h1C00_0004, 1'b1, lineData(32'h1C));
    fetchCheck("post_rst_t7", set5Addr(7), 1'b1, lineData(7));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
